spi_slave_if: RTL

SPI_SLAVE_IF -- requirements
Module: spi_slave_if

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_tx_serializer.sv | 40 ++++
 rtl/spi_slave_if.sv | 126 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave interface.
package spi_pkg;

    localparam int DEFAULT_ADDR_SIZE = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    // True when a received command field belongs to the frame type being shifted.
    function automatic logic cmd_matches(input state_t state, input logic [1:0] cmd);
        logic match;
        match = 1'b0;
        case (state)
            WRITE:     match = (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
            READ_ADD:  match = (cmd == CMD_RD_ADDR);
            READ_DATA: match = (cmd == CMD_RD_DATA);
            default:   match = 1'b0;
        endcase
        return match;
    endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-load, MSB-first shifter that drives miso with RAM read data.
module spi_tx_serializer
    import spi_pkg::*;
#(
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ss_n,
    input  logic                 load,
    input  logic [ADDR_SIZE-1:0] data,
    output logic                 miso
);

    localparam int CNT_W = $clog2(ADDR_SIZE + 1);
    localparam logic [CNT_W-1:0] REMAIN_INIT = CNT_W'(ADDR_SIZE - 1);

    logic [ADDR_SIZE-1:0] shift_reg;
    logic [CNT_W-1:0]     remaining;

    // The MSB goes out on the load edge itself, so miso is valid the cycle after load.
    always_ff @(posedge clk) begin
        if (!rst_n || ss_n) begin
            shift_reg <= '0;
            remaining <= '0;
            miso      <= 1'b0;
        end else if (load) begin
            miso      <= data[ADDR_SIZE-1];
            shift_reg <= {data[ADDR_SIZE-2:0], 1'b0};
            remaining <= REMAIN_INIT;
        end else if (remaining != '0) begin
            miso      <= shift_reg[ADDR_SIZE-1];
            shift_reg <= {shift_reg[ADDR_SIZE-2:0], 1'b0};
            remaining <= remaining - 1'b1;
        end else begin
            miso <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end for a RAM: decodes command frames and serializes read data.
// Optional macro SPI_CMD_CHECK_EN drops frames whose command bits do not match the frame type.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int ADDR_SIZE  = DEFAULT_ADDR_SIZE,
    parameter int FRAME_BITS = ADDR_SIZE + 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [ADDR_SIZE-1:0]  tx_data,
    input  logic                  tx_valid
);

`ifdef SPI_CMD_CHECK_EN
    localparam bit CMD_CHECK = 1'b1;
`else
    localparam bit CMD_CHECK = 1'b0;
`endif

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int TX_W  = $clog2(ADDR_SIZE + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [TX_W-1:0]  TX_FULL  = TX_W'(ADDR_SIZE);
    localparam logic [TX_W-1:0]  TX_LAST  = TX_W'(1);

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [TX_W-1:0]       tx_cnt;
    logic [FRAME_BITS-2:0] shift_reg;
    logic [FRAME_BITS-1:0] next_word;
    logic                  cmd_ok;
    logic                  rd_addr_seen;
    logic                  armed;
    logic                  load;

    // The last frame bit is taken straight from mosi, so the word is ready on its sample edge.
    always_comb begin
        next_word = {shift_reg, mosi};
        cmd_ok    = !CMD_CHECK || cmd_matches(state, next_word[FRAME_BITS-1 -: 2]);
    end

    assign load = (state == READ_DATA) && armed && tx_valid && !ss_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            tx_cnt       <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
            armed        <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state != IDLE && ss_n) begin
                state   <= IDLE;
                bit_cnt <= '0;
                tx_cnt  <= '0;
                armed   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                        if (!ss_n) begin
                            state <= CHK_CMD;
                        end
                    end
                    CHK_CMD: begin
                        if (mosi) begin
                            state <= rd_addr_seen ? READ_DATA : READ_ADD;
                        end else begin
                            state <= WRITE;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        // Counter parks at BIT_FULL so trailing mosi bits are ignored.
                        if (bit_cnt != BIT_FULL) begin
                            shift_reg <= next_word[FRAME_BITS-2:0];
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST && cmd_ok) begin
                                rx_data  <= next_word;
                                rx_valid <= 1'b1;
                                if (state == READ_ADD) begin
                                    rd_addr_seen <= 1'b1;
                                end
                                if (state == READ_DATA) begin
                                    armed <= 1'b1;
                                end
                            end
                        end
                        if (load) begin
                            armed  <= 1'b0;
                            tx_cnt <= TX_FULL;
                        end else if (tx_cnt != '0) begin
                            tx_cnt <= tx_cnt - 1'b1;
                            if (tx_cnt == TX_LAST) begin
                                rd_addr_seen <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    spi_tx_serializer #(
        .ADDR_SIZE(ADDR_SIZE)
    ) u_tx_serializer (
        .clk   (clk),
        .rst_n (rst_n),
        .ss_n  (ss_n),
        .load  (load),
        .data  (tx_data),
        .miso  (miso)
    );

endmodule
